// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART transmit and receive paths:
//   - FSM state encoding (UART_IDLE .. UART_STOP)
//   - legal data-bit range (UART_MIN_DATA_BITS .. UART_MAX_DATA_BITS)
//   - uart_cfg_t: frame settings captured when a frame starts
//   - helpers: stop-bit decode and data-bit clamp
// ----------------------------------------------------------------------------
package uart_pkg;

  localparam logic [2:0] UART_IDLE   = 3'd0;
  localparam logic [2:0] UART_START  = 3'd1;
  localparam logic [2:0] UART_DATA   = 3'd2;
  localparam logic [2:0] UART_PARITY = 3'd3;
  localparam logic [2:0] UART_STOP   = 3'd4;

  localparam int unsigned UART_MIN_DATA_BITS = 5;
  localparam int unsigned UART_MAX_DATA_BITS = 9;

  // Frame settings held constant for the duration of one frame.
  typedef struct packed {
    logic [15:0] bit_rate;   // bit period minus one
    logic [3:0]  data_bits;  // already clamped to the legal range
    logic        two_stop;   // 1: two stop bits
    logic        parity_en;  // 1: parity bit follows the data bits
  } uart_cfg_t;

  // stop_bits 0/1 select one stop bit, 2/3 select two.
  function automatic logic uart_two_stop(input logic [1:0] stop_bits);
    return stop_bits[1];
  endfunction

  function automatic logic [3:0] uart_clamp_data_bits(input logic [3:0] data_bits);
    if (data_bits < 4'(UART_MIN_DATA_BITS)) return 4'(UART_MIN_DATA_BITS);
    if (data_bits > 4'(UART_MAX_DATA_BITS)) return 4'(UART_MAX_DATA_BITS);
    return data_bits;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// ----------------------------------------------------------------------------
// uart_baud_cnt
// Loadable 16-bit down-counter that paces UART bit periods. Loading value V
// makes tick assert V clocks later; the counter then holds at zero until the
// next load, so reloading on every tick yields a period of V+1 clocks.
// Ports:
//   clk      in  clock
//   reset_n  in  asynchronous active-low reset
//   load_i   in  load load_val_i on this edge
//   load_val_i in 16-bit reload value
//   tick_o   out counter is at zero (current bit period ends on this edge)
// ----------------------------------------------------------------------------
module uart_baud_cnt (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load_i,
  input  logic [15:0] load_val_i,
  output logic        tick_o
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != 16'd0) begin
      cnt_d = cnt_q - 16'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of the order blocks are evaluated in.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == 16'd0);

endmodule

// File: rtl/uart_tx_core.sv
// ----------------------------------------------------------------------------
// uart_tx_core
// UART transmitter: accepts words over a valid/ready handshake into a
// one-entry holding register and serialises them LSB-first on txd with
// start bit, 5..9 data bits, optional parity and 1 or 2 stop bits. A held
// word is loaded on the edge that ends the previous stop bit, so
// back-to-back frames have no idle gap.
// Ports:
//   clk, reset_n     clock, asynchronous active-low reset
//   bit_rate         bit period minus one (captured at frame start)
//   data_bits        data bits per frame, clamped to 5..9
//   stop_bits        0/1: one stop bit, 2/3: two stop bits
//   parity_bit       0: even parity, 1: odd parity
//   parity_enabled   insert parity bit after the data bits
//   tx_valid/tx_data offered word (bits above data_bits ignored)
//   tx_ready         holding register empty
//   txd              registered serial output, idle high
//   tx_busy          frame in progress or word held
//   tx_done          one-cycle pulse after the final stop bit
// ----------------------------------------------------------------------------
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int pDUMP = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] bit_rate,
  input  logic [3:0]  data_bits,
  input  logic [1:0]  stop_bits,
  input  logic        parity_bit,
  input  logic        parity_enabled,
  input  logic        tx_valid,
  input  logic [8:0]  tx_data,
  output logic        tx_ready,
  output logic        txd,
  output logic        tx_busy,
  output logic        tx_done
);

  // Waveform dumping is driven by the simulation harness from this
  // parameter; the synthesizable core only carries the hook.
  if (pDUMP != 0) begin : g_dump_hook
  end

  logic [2:0]  state_q,     state_d;
  uart_cfg_t   cfg_q,       cfg_d;
  logic        hold_full_q, hold_full_d;
  logic [8:0]  hold_q,      hold_d;
  logic [8:0]  shift_q,     shift_d;
  logic [3:0]  bit_idx_q,   bit_idx_d;
  logic        stop_cnt_q,  stop_cnt_d;
  logic        parity_q,    parity_d;
  logic        txd_q,       txd_d;
  logic        done_q,      done_d;

  logic        accept;
  logic        load_frame;
  logic        tick;
  logic        baud_load;
  logic [15:0] baud_val;

  uart_baud_cnt u_baud_cnt (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (baud_load),
    .load_val_i (baud_val),
    .tick_o     (tick)
  );

  assign accept = tx_valid && !hold_full_q;

  // NOTE: every signal assigned here gets a default first, so no path through
  // the case statement leaves a variable unassigned (which would infer a latch).
  always_comb begin
    state_d     = state_q;
    cfg_d       = cfg_q;
    hold_full_d = hold_full_q;
    hold_d      = hold_q;
    shift_d     = shift_q;
    bit_idx_d   = bit_idx_q;
    stop_cnt_d  = stop_cnt_q;
    parity_d    = parity_q;
    txd_d       = txd_q;
    done_d      = 1'b0;
    load_frame  = 1'b0;

    case (state_q)
      UART_IDLE: begin
        if (hold_full_q) load_frame = 1'b1;
      end

      UART_START: begin
        if (tick) begin
          state_d   = UART_DATA;
          txd_d     = shift_q[0];
          parity_d  = parity_q ^ shift_q[0];
          shift_d   = {1'b0, shift_q[8:1]};
          bit_idx_d = 4'd0;
        end
      end

      UART_DATA: begin
        if (tick) begin
          if (bit_idx_q == cfg_q.data_bits - 4'd1) begin
            if (cfg_q.parity_en) begin
              state_d = UART_PARITY;
              txd_d   = parity_q;
            end else begin
              state_d    = UART_STOP;
              txd_d      = 1'b1;
              stop_cnt_d = 1'b0;
            end
          end else begin
            // The parity accumulator folds in each bit as it goes out.
            bit_idx_d = bit_idx_q + 4'd1;
            txd_d     = shift_q[0];
            parity_d  = parity_q ^ shift_q[0];
            shift_d   = {1'b0, shift_q[8:1]};
          end
        end
      end

      UART_PARITY: begin
        if (tick) begin
          state_d    = UART_STOP;
          txd_d      = 1'b1;
          stop_cnt_d = 1'b0;
        end
      end

      UART_STOP: begin
        if (tick) begin
          if (stop_cnt_q == cfg_q.two_stop) begin
            done_d = 1'b1;
            if (hold_full_q) begin
              load_frame = 1'b1;
            end else begin
              state_d = UART_IDLE;
            end
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = UART_IDLE;
        txd_d   = 1'b1;
      end
    endcase

    // Frame load: the held word moves to the shifter and the frame settings
    // are captured, so later config changes only affect later frames.
    if (load_frame) begin
      state_d           = UART_START;
      txd_d             = 1'b0;
      shift_d           = hold_q;
      parity_d          = parity_bit;
      cfg_d.bit_rate    = bit_rate;
      cfg_d.data_bits   = uart_clamp_data_bits(data_bits);
      cfg_d.two_stop    = uart_two_stop(stop_bits);
      cfg_d.parity_en   = parity_enabled;
      hold_full_d       = 1'b0;
    end

    // A word accepted on the load edge refills the holding register.
    if (accept) begin
      hold_full_d = 1'b1;
      hold_d      = tx_data;
    end
  end

  // On a load edge cfg_q is not yet updated, so use the live bit_rate.
  assign baud_load = load_frame || ((state_q != UART_IDLE) && tick);
  assign baud_val  = load_frame ? bit_rate : cfg_q.bit_rate;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= UART_IDLE;
      cfg_q       <= '0;
      hold_full_q <= 1'b0;
      bit_idx_q   <= 4'd0;
      stop_cnt_q  <= 1'b0;
      parity_q    <= 1'b0;
      txd_q       <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfg_q       <= cfg_d;
      hold_full_q <= hold_full_d;
      bit_idx_q   <= bit_idx_d;
      stop_cnt_q  <= stop_cnt_d;
      parity_q    <= parity_d;
      txd_q       <= txd_d;
      done_q      <= done_d;
    end
  end

  // NOTE: the data registers carry no reset; they are only read after a load
  // qualified by hold_full_q/state_q, which are reset.
  always_ff @(posedge clk) begin
    hold_q  <= hold_d;
    shift_q <= shift_d;
  end

  assign tx_ready = !hold_full_q;
  assign tx_busy  = (state_q != UART_IDLE) || hold_full_q;
  assign txd      = txd_q;
  assign tx_done  = done_q;

endmodule
